// File: rtl/tile_board_ctrl_pkg.sv
// Shared types and constants for the 3x3 sliding-tile board controller.
// The neighbour helper returns {legal, target_slot} for a blank move.
package tile_board_ctrl_pkg;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_e;

   typedef logic [3:0] tile_id_t;

   localparam int       NUM_SLOTS  = 9;
   localparam int       GRID_W     = 3;
   localparam tile_id_t BLANK_TILE = 4'd8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_VB   = 3'd1,
      APPLY     = 3'd2,
      SHUF_WAIT = 3'd3,
      SHUF_RUN  = 3'd4
   } state_e;

   function automatic logic [4:0] move_target(input logic [3:0] pos, input dir_e dir);
      logic [3:0] col;
      logic [4:0] res;
      col = pos % 4'(GRID_W);
      res = {1'b0, pos};
      case (dir)
         UP:      if (pos >= 4'd3)  res = {1'b1, pos - 4'd3};
         DOWN:    if (pos <= 4'd5)  res = {1'b1, pos + 4'd3};
         LEFT:    if (col != 4'd0)  res = {1'b1, pos - 4'd1};
         RIGHT:   if (col != 4'd2)  res = {1'b1, pos + 4'd1};
         default: res = {1'b0, pos};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/tile_board_ctrl_lfsr.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, stepping every clock.
// Supplies pseudo-random blank move directions for board shuffling.
module lfsr_16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] state
);

   logic fb;

   assign fb = state[15] ^ state[13] ^ state[12] ^ state[10];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= SEED;
      else        state <= {state[14:0], fb};
   end

endmodule

// File: rtl/tile_board_ctrl.sv
// 3x3 sliding-tile board: blank moves are applied on the vertical-blank
// rising edge, shuffles run one random move per cycle after a vblank edge.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | ready for a move command or a shuffle request
// WAIT_VB   | move direction latched, waiting for vblnk rising edge
// APPLY     | one cycle; board updated on the edge that ends it
// SHUF_WAIT | shuffle requested, waiting for vblnk rising edge
// SHUF_RUN  | one random blank move per cycle until the timer expires
module tile_board_ctrl
   import tile_board_ctrl_pkg::*;
#(
   parameter int          SHUFFLE_MOVES = 64,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vblnk,
   input  logic        cmd_valid,
   input  logic [1:0]  cmd_dir,
   output logic        cmd_ready,
   input  logic        shuffle_req,
   output logic [35:0] slot_img,
   output logic [3:0]  blank_pos,
   output logic [9:0]  move_cnt,
   output logic        solved,
   output logic        busy
);

   state_e     state_q, state_d;
   tile_id_t   board_q [NUM_SLOTS];
   logic [3:0] blank_q;
   logic [9:0] move_cnt_q;
   dir_e       dir_q;
   logic       vblnk_q;
   logic [7:0] shuf_cnt_q;
   logic [15:0] lfsr;

   logic       vb_rise;
   logic       latch_cmd;
   logic       apply_move;
   logic       count_move;
   logic       load_shuf;
   logic       clr_cnt;
   dir_e       mv_dir;
   logic [4:0] mv_tgt;
   logic       mv_legal;
   logic [3:0] mv_nbr;
   logic       unused_lfsr;

   lfsr_16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .state (lfsr)
   );

   assign unused_lfsr = ^lfsr[15:2];
   assign vb_rise     = vblnk && !vblnk_q;
   assign cmd_ready   = (state_q == IDLE) && !shuffle_req;
   assign busy        = (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      latch_cmd  = 1'b0;
      apply_move = 1'b0;
      count_move = 1'b0;
      load_shuf  = 1'b0;
      clr_cnt    = 1'b0;
      mv_dir     = dir_q;
      case (state_q)
         IDLE: begin
            if (shuffle_req) begin
               state_d = SHUF_WAIT;
            end else if (cmd_valid) begin
               latch_cmd = 1'b1;
               state_d   = WAIT_VB;
            end
         end
         WAIT_VB: if (vb_rise) state_d = APPLY;
         APPLY: begin
            apply_move = 1'b1;
            count_move = 1'b1;
            state_d    = IDLE;
         end
         SHUF_WAIT: begin
            if (vb_rise) begin
               load_shuf = 1'b1;
               state_d   = SHUF_RUN;
            end
         end
         SHUF_RUN: begin
            apply_move = 1'b1;
            mv_dir     = dir_e'(lfsr[1:0]);
            if (shuf_cnt_q == 8'd1) begin
               clr_cnt = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mv_tgt   = move_target(blank_q, mv_dir);
   assign mv_legal = mv_tgt[4];
   assign mv_nbr   = mv_tgt[3:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vblnk_q <= 1'b0;
         dir_q   <= UP;
      end else begin
         state_q <= state_d;
         vblnk_q <= vblnk;
         if (latch_cmd) dir_q <= dir_e'(cmd_dir);
      end
   end

   // Shuffle length timer: loaded on entry, terminal count at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     shuf_cnt_q <= 8'd0;
      else if (load_shuf)             shuf_cnt_q <= 8'(SHUFFLE_MOVES);
      else if (state_q == SHUF_RUN)   shuf_cnt_q <= shuf_cnt_q - 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SLOTS; i++) board_q[i] <= tile_id_t'(i);
         blank_q <= 4'(NUM_SLOTS - 1);
      end else if (apply_move && mv_legal) begin
         board_q[blank_q] <= board_q[mv_nbr];
         board_q[mv_nbr]  <= BLANK_TILE;
         blank_q          <= mv_nbr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  move_cnt_q <= 10'd0;
      else if (clr_cnt || load_shuf) move_cnt_q <= 10'd0;
      else if (count_move && mv_legal && (move_cnt_q != 10'd1023))
         move_cnt_q <= move_cnt_q + 10'd1;
   end

   always_comb begin
      slot_img = '0;
      solved   = 1'b1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slot_img[4*i +: 4] = board_q[i];
         if (board_q[i] != tile_id_t'(i)) solved = 1'b0;
      end
   end

   assign blank_pos = blank_q;
   assign move_cnt  = move_cnt_q;

endmodule

// File: tb/tb_tile_board_ctrl.sv
// Self-checking bench for tile_board_ctrl: random moves and shuffles are
// compared against a row/column board model and a polynomial LFSR model.
module tb_tile_board_ctrl;

   localparam int          SHUF = 64;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam logic [35:0] SOLVED_IMG = 36'h876543210;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        vblnk = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_dir = 2'd0;
   logic        cmd_ready;
   logic        shuffle_req = 1'b0;
   logic [35:0] slot_img;
   logic [3:0]  blank_pos;
   logic [9:0]  move_cnt;
   logic        solved;
   logic        busy;

   int errors = 0;
   int checks = 0;

   int mb [9];
   int mblank;
   int mcnt;
   logic [15:0] ref_lfsr;

   tile_board_ctrl #(.SHUFFLE_MOVES(SHUF), .LFSR_SEED(SEED)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .vblnk       (vblnk),
      .cmd_valid   (cmd_valid),
      .cmd_dir     (cmd_dir),
      .cmd_ready   (cmd_ready),
      .shuffle_req (shuffle_req),
      .slot_img    (slot_img),
      .blank_pos   (blank_pos),
      .move_cnt    (move_cnt),
      .solved      (solved),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Reference LFSR: next bit is the parity of the tapped bits 16,14,13,11.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ref_lfsr <= SEED;
      else        ref_lfsr <= {ref_lfsr[14:0], ^(ref_lfsr & 16'hB400)};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 9; i++) mb[i] = i;
      mblank = 8;
      mcnt   = 0;
   endfunction

   function automatic void model_move(input int dir, input bit count);
      int r, c, nr, nc, t;
      r  = mblank / 3;
      c  = mblank % 3;
      nr = r;
      nc = c;
      case (dir)
         0: nr = r - 1;
         1: nr = r + 1;
         2: nc = c - 1;
         default: nc = c + 1;
      endcase
      if (nr >= 0 && nr < 3 && nc >= 0 && nc < 3) begin
         t         = nr * 3 + nc;
         mb[mblank] = mb[t];
         mb[t]     = 8;
         mblank    = t;
         if (count && mcnt < 1023) mcnt++;
      end
   endfunction

   function automatic logic [35:0] model_img();
      logic [35:0] v;
      v = '0;
      for (int i = 0; i < 9; i++) v[4*i +: 4] = 4'(mb[i]);
      return v;
   endfunction

   function automatic bit model_solved();
      bit s;
      s = 1'b1;
      for (int i = 0; i < 9; i++) if (mb[i] != i) s = 1'b0;
      return s;
   endfunction

   task automatic issue_cmd(input logic [1:0] d);
      int n;
      n = 0;
      while (!cmd_ready && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL cmd_ready_wait: got %b want 1 within 20 cycles", cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_dir   = d;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic pulse_vb();
      vblnk = 1'b1;
      tick();
      tick();
      vblnk = 1'b0;
   endtask

   task automatic do_move(input logic [1:0] d);
      issue_cmd(d);
      pulse_vb();
      model_move(int'(d), 1'b1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic run_shuf_model();
      for (int j = 0; j < SHUF; j++) begin
         model_move(int'(ref_lfsr[1:0]), 1'b0);
         tick();
      end
      mcnt = 0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checks += 6;
      if (slot_img !== SOLVED_IMG) begin errors++; $display("FAIL reset_img: got %h want %h", slot_img, SOLVED_IMG); end
      if (blank_pos !== 4'd8) begin errors++; $display("FAIL reset_blank: got %0d want 8", blank_pos); end
      if (move_cnt !== 10'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", move_cnt); end
      if (solved !== 1'b1) begin errors++; $display("FAIL reset_solved: got %b want 1", solved); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_cmd_up();
      issue_cmd(2'd0);
      checks += 2;
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL up_ready_wait: got %b want 0", cmd_ready); end
      if (busy !== 1'b1) begin errors++; $display("FAIL up_busy_wait: got %b want 1", busy); end
      vblnk = 1'b1;
      tick();
      checks += 2;
      if (blank_pos !== 4'd8) begin errors++; $display("FAIL up_early: blank %0d want 8", blank_pos); end
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL up_ready_apply: got %b want 0", cmd_ready); end
      tick();
      vblnk = 1'b0;
      model_move(0, 1'b1);
      checks += 6;
      if (blank_pos !== 4'd5) begin errors++; $display("FAIL up_blank: got %0d want 5", blank_pos); end
      if (slot_img[23:20] !== 4'd8) begin errors++; $display("FAIL up_slot5: got %0d want 8", slot_img[23:20]); end
      if (slot_img[35:32] !== 4'd5) begin errors++; $display("FAIL up_slot8: got %0d want 5", slot_img[35:32]); end
      if (move_cnt !== 10'd1) begin errors++; $display("FAIL up_cnt: got %0d want 1", move_cnt); end
      if (solved !== 1'b0) begin errors++; $display("FAIL up_solved: got %b want 0", solved); end
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL up_ready_done: got %b want 1", cmd_ready); end
   endtask

   task automatic test_illegal();
      do_reset();
      do_move(2'd3);
      checks += 3;
      if (slot_img !== SOLVED_IMG) begin errors++; $display("FAIL illegal_img: got %h want %h", slot_img, SOLVED_IMG); end
      if (move_cnt !== 10'd0) begin errors++; $display("FAIL illegal_cnt: got %0d want 0", move_cnt); end
      if (solved !== 1'b1) begin errors++; $display("FAIL illegal_solved: got %b want 1", solved); end
      do_move(2'd0);
      do_move(2'd1);
      checks += 3;
      if (solved !== 1'b1) begin errors++; $display("FAIL updown_solved: got %b want 1", solved); end
      if (move_cnt !== 10'd2) begin errors++; $display("FAIL updown_cnt: got %0d want 2", move_cnt); end
      if (slot_img !== SOLVED_IMG) begin errors++; $display("FAIL updown_img: got %h want %h", slot_img, SOLVED_IMG); end
   endtask

   task automatic test_vblnk_held();
      do_reset();
      vblnk = 1'b1;
      tick();
      tick();
      issue_cmd(2'd2);
      for (int k = 0; k < 3; k++) tick();
      checks += 2;
      if (blank_pos !== 4'd8) begin errors++; $display("FAIL held_no_move: blank %0d want 8", blank_pos); end
      if (busy !== 1'b1) begin errors++; $display("FAIL held_busy: got %b want 1", busy); end
      vblnk = 1'b0;
      tick();
      vblnk = 1'b1;
      tick();
      checks++;
      if (blank_pos !== 4'd8) begin errors++; $display("FAIL held_early: blank %0d want 8", blank_pos); end
      tick();
      vblnk = 1'b0;
      model_move(2, 1'b1);
      checks += 2;
      if (slot_img !== model_img()) begin errors++; $display("FAIL held_img: got %h want %h", slot_img, model_img()); end
      if (blank_pos !== 4'(mblank)) begin errors++; $display("FAIL held_blank: got %0d want %0d", blank_pos, mblank); end
   endtask

   task automatic test_random_moves();
      logic [1:0] d;
      for (int n = 0; n < 40; n++) begin
         d = 2'($urandom_range(0, 3));
         do_move(d);
         checks += 4;
         if (slot_img !== model_img()) begin errors++; $display("FAIL rnd_img[%0d]: got %h want %h", n, slot_img, model_img()); end
         if (blank_pos !== 4'(mblank)) begin errors++; $display("FAIL rnd_blank[%0d]: got %0d want %0d", n, blank_pos, mblank); end
         if (move_cnt !== 10'(mcnt)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, move_cnt, mcnt); end
         if (solved !== model_solved()) begin errors++; $display("FAIL rnd_solved[%0d]: got %b want %b", n, solved, model_solved()); end
      end
   endtask

   task automatic test_shuffle();
      int w, busy_n, seen;
      bit perm_ok;
      w = int'($urandom_range(0, 5));
      shuffle_req = 1'b1;
      cmd_valid   = 1'b1;
      cmd_dir     = 2'($urandom_range(0, 3));
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL shuf_ready: got %b want 0", cmd_ready); end
      tick();
      shuffle_req = 1'b0;
      cmd_valid   = 1'b0;
      busy_n = 0;
      for (int k = 0; k < w; k++) begin
         if (busy) busy_n++;
         tick();
      end
      vblnk = 1'b1;
      if (busy) busy_n++;
      tick();
      for (int j = 0; j < SHUF; j++) begin
         if (busy) busy_n++;
         model_move(int'(ref_lfsr[1:0]), 1'b0);
         tick();
      end
      mcnt  = 0;
      vblnk = 1'b0;
      seen    = 0;
      perm_ok = (slot_img[4*blank_pos +: 4] == 4'd8);
      for (int i = 0; i < 9; i++) begin
         if (slot_img[4*i +: 4] > 4'd8) perm_ok = 1'b0;
         else seen |= (1 << slot_img[4*i +: 4]);
      end
      if (seen != 9'h1FF) perm_ok = 1'b0;
      checks += 6;
      if (busy_n != w + 1 + SHUF) begin errors++; $display("FAIL shuf_busy_len: got %0d want %0d", busy_n, w + 1 + SHUF); end
      if (busy !== 1'b0) begin errors++; $display("FAIL shuf_done_busy: got %b want 0", busy); end
      if (move_cnt !== 10'd0) begin errors++; $display("FAIL shuf_cnt: got %0d want 0", move_cnt); end
      if (slot_img !== model_img()) begin errors++; $display("FAIL shuf_img: got %h want %h", slot_img, model_img()); end
      if (blank_pos !== 4'(mblank)) begin errors++; $display("FAIL shuf_blank: got %0d want %0d", blank_pos, mblank); end
      if (perm_ok !== 1'b1) begin errors++; $display("FAIL shuf_perm: got %b want 1", perm_ok); end
   endtask

   task automatic test_shuffle_reenter();
      do_move(2'($urandom_range(0, 3)));
      shuffle_req = 1'b1;
      tick();
      vblnk = 1'b1;
      tick();
      run_shuf_model();
      checks += 3;
      if (busy !== 1'b0) begin errors++; $display("FAIL reent_idle: got %b want 0", busy); end
      if (move_cnt !== 10'd0) begin errors++; $display("FAIL reent_cnt: got %0d want 0", move_cnt); end
      if (slot_img !== model_img()) begin errors++; $display("FAIL reent_img1: got %h want %h", slot_img, model_img()); end
      tick();
      shuffle_req = 1'b0;
      vblnk = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL reent_busy: got %b want 1", busy); end
      tick();
      vblnk = 1'b1;
      tick();
      run_shuf_model();
      vblnk = 1'b0;
      checks += 2;
      if (slot_img !== model_img()) begin errors++; $display("FAIL reent_img2: got %h want %h", slot_img, model_img()); end
      if (blank_pos !== 4'(mblank)) begin errors++; $display("FAIL reent_blank: got %0d want %0d", blank_pos, mblank); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      do_move(2'd0);
      issue_cmd(2'd2);
      rst_n = 1'b0;
      #1;
      model_reset();
      checks += 4;
      if (slot_img !== SOLVED_IMG) begin errors++; $display("FAIL rmid_wait_img: got %h want %h", slot_img, SOLVED_IMG); end
      if (blank_pos !== 4'd8) begin errors++; $display("FAIL rmid_wait_blank: got %0d want 8", blank_pos); end
      if (move_cnt !== 10'd0) begin errors++; $display("FAIL rmid_wait_cnt: got %0d want 0", move_cnt); end
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_wait_ctl: busy %b ready %b want 0 1", busy, cmd_ready); end
      tick();
      rst_n = 1'b1;
      pulse_vb();
      tick();
      checks += 2;
      if (slot_img !== SOLVED_IMG) begin errors++; $display("FAIL rmid_wait_after: got %h want %h", slot_img, SOLVED_IMG); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rmid_wait_after_busy: got %b want 0", busy); end

      shuffle_req = 1'b1;
      tick();
      shuffle_req = 1'b0;
      vblnk = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) tick();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL rmid_run_busy: got %b want 1", busy); end
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (slot_img !== SOLVED_IMG) begin errors++; $display("FAIL rmid_run_img: got %h want %h", slot_img, SOLVED_IMG); end
      if (blank_pos !== 4'd8) begin errors++; $display("FAIL rmid_run_blank: got %0d want 8", blank_pos); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rmid_run_busy0: got %b want 0", busy); end
      tick();
      rst_n = 1'b1;
      vblnk = 1'b0;
      tick();
      pulse_vb();
      tick();
      checks += 2;
      if (slot_img !== SOLVED_IMG) begin errors++; $display("FAIL rmid_run_after: got %h want %h", slot_img, SOLVED_IMG); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rmid_run_after_busy: got %b want 0", busy); end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int n = 0; n < 1030; n++) begin
         do_move((n % 2 == 0) ? 2'd0 : 2'd1);
         if (n == 1022) begin
            checks++;
            if (move_cnt !== 10'd1023) begin errors++; $display("FAIL sat_reach: got %0d want 1023", move_cnt); end
         end
      end
      checks += 3;
      if (move_cnt !== 10'd1023) begin errors++; $display("FAIL sat_hold: got %0d want 1023", move_cnt); end
      if (move_cnt !== 10'(mcnt)) begin errors++; $display("FAIL sat_model: got %0d want %0d", move_cnt, mcnt); end
      if (slot_img !== model_img()) begin errors++; $display("FAIL sat_img: got %h want %h", slot_img, model_img()); end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_cmd_up();
      test_illegal();
      test_vblnk_held();
      test_random_moves();
      test_shuffle();
      test_shuffle_reenter();
      test_reset_mid();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
